// File: rtl/exe_pkg.sv
// Shared encodings for the registered execute stage: command codes, shifter types,
// status-register bit positions and the stage FSM state type.
package exe_pkg;

    // CMP is issued as EXE_SUB and TST as EXE_AND; LDR/STR are issued as EXE_ADD.
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MUL = 4'b1010;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    localparam int unsigned SR_N = 3;
    localparam int unsigned SR_C = 2;
    localparam int unsigned SR_Z = 1;
    localparam int unsigned SR_V = 0;

    typedef enum logic {
        IDLE,
        MUL_RUN
    } exe_state_e;

endpackage

// File: rtl/exe_val2_shifter.sv
// Combinational second-operand generator: 12-bit offset for memory ops, rotated
// 8-bit immediate, or shifted register. All shift amounts are taken modulo DW.
module exe_val2_shifter
    import exe_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic          mem_cmd,
    input  logic          imm,
    input  logic [11:0]   shift_operand,
    input  logic [DW-1:0] val_rm,
    output logic [DW-1:0] val2
);

    logic [2*DW-1:0] dbl;
    logic [31:0]     amt;
    logic [DW-1:0]   imm8;

    assign imm8 = {{(DW-8){1'b0}}, shift_operand[7:0]};

    // Select the operand form; rotates are done by shifting a doubled copy.
    always_comb begin
        val2 = '0;
        amt  = '0;
        dbl  = '0;
        if (mem_cmd) begin
            val2 = {{(DW-12){1'b0}}, shift_operand};
        end else if (imm) begin
            amt  = (32'(shift_operand[11:8]) << 1) % DW;
            dbl  = {imm8, imm8};
            val2 = DW'(dbl >> amt);
        end else begin
            amt = 32'(shift_operand[11:7]) % DW;
            case (shift_operand[6:5])
                SH_LSL: val2 = val_rm << amt;
                SH_LSR: val2 = val_rm >> amt;
                SH_ASR: val2 = $signed(val_rm) >>> amt;
                default: begin
                    dbl  = {val_rm, val_rm};
                    val2 = DW'(dbl >> amt);
                end
            endcase
        end
    end

endmodule

// File: rtl/exe_stage_pipe.sv
// Registered execute stage with valid/ready on both sides, internal status register,
// multicycle multiply and flush. Optional feature: define EXE_STALL_CNT_EN to add a
// saturating 32-bit count of cycles where upstream is valid but not accepted.
module exe_stage_pipe
    import exe_pkg::*;
#(
    parameter int unsigned DW       = 32,
    parameter int unsigned MUL_LAT  = 4,
    parameter int unsigned BR_SHIFT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    exe_cmd,
    input  logic          mem_r_en,
    input  logic          mem_w_en,
    input  logic          s_bit,
    input  logic [DW-1:0] pc,
    input  logic [DW-1:0] val_rn,
    input  logic [DW-1:0] val_rm,
    input  logic          imm,
    input  logic [11:0]   shift_operand,
    input  logic [23:0]   signed_imm_24,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] alu_result,
    output logic [DW-1:0] br_addr,
    output logic [DW-1:0] st_data,
    output logic          out_mem_r_en,
    output logic          out_mem_w_en,
    output logic [3:0]    status
`ifdef EXE_STALL_CNT_EN
    ,
    output logic [31:0]   stall_cnt
`endif
);

    localparam int unsigned CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    exe_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [DW-1:0] mul_br_q, mul_br_d, mul_st_q, mul_st_d;
    logic          mul_s_q, mul_s_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] alu_result_q, alu_result_d, br_addr_q, br_addr_d, st_data_q, st_data_d;
    logic          out_mem_r_en_q, out_mem_r_en_d, out_mem_w_en_q, out_mem_w_en_d;
    logic [3:0]    status_q, status_d;

    logic          mem_cmd, is_mul, accept, load_en;
    logic [3:0]    op_cmd;
    logic [DW-1:0] val2, br_off, br_target, mul_prod;
    logic [DW-1:0] addend, alu_res;
    logic [DW:0]   sum;
    logic          cin, arith, logic_op;
    logic [3:0]    alu_flags, mul_flags;

    assign mem_cmd  = mem_r_en | mem_w_en;
    assign op_cmd   = mem_cmd ? EXE_ADD : exe_cmd;
    assign is_mul   = (op_cmd == EXE_MUL);
    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    exe_val2_shifter #(
        .DW (DW)
    ) u_val2 (
        .mem_cmd       (mem_cmd),
        .imm           (imm),
        .shift_operand (shift_operand),
        .val_rm        (val_rm),
        .val2          (val2)
    );

    if (DW >= 24) begin : g_br_wide
        assign br_off = {{(DW-24){signed_imm_24[23]}}, signed_imm_24};
    end else begin : g_br_narrow
        assign br_off = signed_imm_24[DW-1:0];
    end
    assign br_target = pc + (br_off << BR_SHIFT);

    assign mul_prod = mul_a_q * mul_b_q;

    // Flags after a multiply: N and Z from the product, C and V preserved.
    always_comb begin
        mul_flags       = status_q;
        mul_flags[SR_N] = mul_prod[DW-1];
        mul_flags[SR_Z] = (mul_prod == '0);
    end

    // Single-cycle ALU; subtraction is a + ~b + cin so C comes out as NOT borrow.
    always_comb begin
        addend   = val2;
        cin      = 1'b0;
        arith    = 1'b0;
        logic_op = 1'b0;
        alu_res  = '0;
        case (op_cmd)
            EXE_MOV: begin alu_res = val2;          logic_op = 1'b1; end
            EXE_MVN: begin alu_res = ~val2;         logic_op = 1'b1; end
            EXE_AND: begin alu_res = val_rn & val2; logic_op = 1'b1; end
            EXE_ORR: begin alu_res = val_rn | val2; logic_op = 1'b1; end
            EXE_EOR: begin alu_res = val_rn ^ val2; logic_op = 1'b1; end
            EXE_ADD: arith = 1'b1;
            EXE_ADC: begin arith = 1'b1; cin = status_q[SR_C]; end
            EXE_SUB: begin arith = 1'b1; addend = ~val2; cin = 1'b1; end
            EXE_SBC: begin arith = 1'b1; addend = ~val2; cin = status_q[SR_C]; end
            default: ;
        endcase
        sum = {1'b0, val_rn} + {1'b0, addend} + {{DW{1'b0}}, cin};
        if (arith) begin
            alu_res = sum[DW-1:0];
        end
        alu_flags = status_q;
        if (arith || logic_op) begin
            alu_flags[SR_N] = alu_res[DW-1];
            alu_flags[SR_Z] = (alu_res == '0);
        end
        if (arith) begin
            alu_flags[SR_C] = sum[DW];
            alu_flags[SR_V] = (val_rn[DW-1] == addend[DW-1]) && (alu_res[DW-1] != val_rn[DW-1]);
        end
    end

    // Next-state: flush wins; otherwise accept, multiply sequencing and output drain.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        mul_a_d        = mul_a_q;
        mul_b_d        = mul_b_q;
        mul_br_d       = mul_br_q;
        mul_st_d       = mul_st_q;
        mul_s_d        = mul_s_q;
        alu_result_d   = alu_result_q;
        br_addr_d      = br_addr_q;
        st_data_d      = st_data_q;
        out_mem_r_en_d = out_mem_r_en_q;
        out_mem_w_en_d = out_mem_w_en_q;
        status_d       = status_q;
        out_valid_d    = out_valid_q;
        load_en        = 1'b0;
        if (flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept && is_mul) begin
                        mul_a_d  = val_rn;
                        mul_b_d  = val_rm;
                        mul_br_d = br_target;
                        mul_st_d = val_rm;
                        mul_s_d  = s_bit;
                        cnt_d    = CW'(MUL_LAT - 1);
                        state_d  = MUL_RUN;
                    end else if (accept) begin
                        load_en        = 1'b1;
                        alu_result_d   = alu_res;
                        br_addr_d      = br_target;
                        st_data_d      = val_rm;
                        out_mem_r_en_d = mem_r_en;
                        out_mem_w_en_d = mem_w_en;
                        if (s_bit && !mem_cmd) begin
                            status_d = alu_flags;
                        end
                    end
                end
                MUL_RUN: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end else if (!out_valid_q || out_ready) begin
                        load_en        = 1'b1;
                        alu_result_d   = mul_prod;
                        br_addr_d      = mul_br_q;
                        st_data_d      = mul_st_q;
                        out_mem_r_en_d = 1'b0;
                        out_mem_w_en_d = 1'b0;
                        if (mul_s_q) begin
                            status_d = mul_flags;
                        end
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (load_en) begin
                out_valid_d = 1'b1;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            mul_a_q        <= '0;
            mul_b_q        <= '0;
            mul_br_q       <= '0;
            mul_st_q       <= '0;
            mul_s_q        <= 1'b0;
            out_valid_q    <= 1'b0;
            alu_result_q   <= '0;
            br_addr_q      <= '0;
            st_data_q      <= '0;
            out_mem_r_en_q <= 1'b0;
            out_mem_w_en_q <= 1'b0;
            status_q       <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            mul_a_q        <= mul_a_d;
            mul_b_q        <= mul_b_d;
            mul_br_q       <= mul_br_d;
            mul_st_q       <= mul_st_d;
            mul_s_q        <= mul_s_d;
            out_valid_q    <= out_valid_d;
            alu_result_q   <= alu_result_d;
            br_addr_q      <= br_addr_d;
            st_data_q      <= st_data_d;
            out_mem_r_en_q <= out_mem_r_en_d;
            out_mem_w_en_q <= out_mem_w_en_d;
            status_q       <= status_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign alu_result   = alu_result_q;
    assign br_addr      = br_addr_q;
    assign st_data      = st_data_q;
    assign out_mem_r_en = out_mem_r_en_q;
    assign out_mem_w_en = out_mem_w_en_q;
    assign status       = status_q;

`ifdef EXE_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating stall counter; deliberately untouched by flush.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (in_valid && !in_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_exe_stage_pipe.sv
// Directed bench for exe_stage_pipe with default parameters (DW=32, MUL_LAT=4).
module tb_exe_stage_pipe;
    import exe_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  exe_cmd = '0;
    logic        mem_r_en = 1'b0;
    logic        mem_w_en = 1'b0;
    logic        s_bit = 1'b0;
    logic [31:0] pc = 32'h100;
    logic [31:0] val_rn = '0;
    logic [31:0] val_rm = '0;
    logic        imm = 1'b0;
    logic [11:0] shift_operand = '0;
    logic [23:0] signed_imm_24 = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] alu_result, br_addr, st_data;
    logic        out_mem_r_en, out_mem_w_en;
    logic [3:0]  status;
`ifdef EXE_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    exe_stage_pipe dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .exe_cmd       (exe_cmd),
        .mem_r_en      (mem_r_en),
        .mem_w_en      (mem_w_en),
        .s_bit         (s_bit),
        .pc            (pc),
        .val_rn        (val_rn),
        .val_rm        (val_rm),
        .imm           (imm),
        .shift_operand (shift_operand),
        .signed_imm_24 (signed_imm_24),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .alu_result    (alu_result),
        .br_addr       (br_addr),
        .st_data       (st_data),
        .out_mem_r_en  (out_mem_r_en),
        .out_mem_w_en  (out_mem_w_en),
        .status        (status)
`ifdef EXE_STALL_CNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                         input logic [11:0] so, input logic s, input logic im,
                         input logic mr, input logic mw);
        in_valid      = 1'b1;
        exe_cmd       = cmd;
        val_rn        = rn;
        val_rm        = rm;
        shift_operand = so;
        s_bit         = s;
        imm           = im;
        mem_r_en      = mr;
        mem_w_en      = mw;
    endtask

    initial begin
        #2;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_alu", alu_result, 32'd0);
        check_eq("rst_status", 32'(status), 32'd0);
        check_eq("rst_br", br_addr, 32'd0);
        #10 rst = 1'b1;
        step();

        // ADD 5+7 with S
        issue(EXE_ADD, 32'd5, 32'd7, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 check_eq("add_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check_eq("add_valid", 32'(out_valid), 32'd1);
        check_eq("add_res", alu_result, 32'd12);
        check_eq("add_status", 32'(status), 32'h0);
        check_eq("add_st", st_data, 32'd7);
        check_eq("add_br", br_addr, 32'h100);

        // SUB 0x80000000-1: signed overflow, no borrow
        issue(EXE_SUB, 32'h8000_0000, 32'd1, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check_eq("sub_res", alu_result, 32'h7FFF_FFFF);
        check_eq("sub_status", 32'(status), 32'b0101);

        // ADC 1+1 with C=1, no S
        issue(EXE_ADC, 32'd1, 32'd1, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check_eq("adc_c1_res", alu_result, 32'd3);
        check_eq("adc_c1_status", 32'(status), 32'b0101);

        // MOV rotated immediate, negative branch offset
        pc            = 32'h1000;
        signed_imm_24 = 24'hFFFFFE;
        issue(EXE_MOV, 32'd0, 32'd0, 12'h2FF, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check_eq("mov_res", alu_result, 32'hF000_000F);
        check_eq("mov_br", br_addr, 32'h0000_0FFE);
        check_eq("mov_status", 32'(status), 32'b0101);
        pc            = 32'h100;
        signed_imm_24 = '0;

        // MUL 3 * -2 with S: four busy cycles then result
        issue(EXE_MUL, 32'd3, 32'hFFFF_FFFE, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("mul_busy_ready%0d", k), 32'(in_ready), 32'd0);
            check_eq($sformatf("mul_busy_valid%0d", k), 32'(out_valid), 32'd0);
            step();
        end
        check_eq("mul_valid", 32'(out_valid), 32'd1);
        check_eq("mul_res", alu_result, 32'hFFFF_FFFA);
        check_eq("mul_status", 32'(status), 32'b1101);
        check_eq("mul_st", st_data, 32'hFFFF_FFFE);

        // ADD with ASR #4 on rm
        issue(EXE_ADD, 32'd1, 32'h8000_0000, 12'h240, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check_eq("asr_res", alu_result, 32'hF800_0001);
        check_eq("asr_status", 32'(status), 32'b1000);

        // LDR: 12-bit offset, SR untouched even with S
        issue(EXE_ADD, 32'h100, 32'd0, 12'hFFF, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        check_eq("ldr_res", alu_result, 32'h0000_10FF);
        check_eq("ldr_status", 32'(status), 32'b1000);
        check_eq("ldr_mem_r", 32'(out_mem_r_en), 32'd1);

        // Backpressure for three cycles with SUB 0-1 waiting
        out_ready = 1'b0;
        issue(EXE_SUB, 32'd0, 32'd1, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("bp_ready%0d", k), 32'(in_ready), 32'd0);
            check_eq($sformatf("bp_valid%0d", k), 32'(out_valid), 32'd1);
            check_eq($sformatf("bp_res%0d", k), alu_result, 32'h0000_10FF);
            check_eq($sformatf("bp_status%0d", k), 32'(status), 32'b1000);
            step();
        end
        out_ready = 1'b1;
        #1 check_eq("bp_release_ready", 32'(in_ready), 32'd1);
        step();
        check_eq("sub01_valid", 32'(out_valid), 32'd1);
        check_eq("sub01_res", alu_result, 32'hFFFF_FFFF);
        check_eq("sub01_status", 32'(status), 32'b1000);
        check_eq("sub01_mem_r", 32'(out_mem_r_en), 32'd0);

        // Back-to-back ADC sees C=0 from the borrow
        issue(EXE_ADC, 32'd0, 32'd0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        check_eq("adc_c0_res", alu_result, 32'd0);
        check_eq("adc_c0_status", 32'(status), 32'b0010);

        // Flush during MUL_RUN; the concurrent ADD is ignored
        issue(EXE_MUL, 32'd2, 32'd3, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        step();
        issue(EXE_ADD, 32'd5, 32'd7, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        #1 check_eq("flush_in_ready", 32'(in_ready), 32'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_eq("flush_valid", 32'(out_valid), 32'd0);
        check_eq("flush_ready", 32'(in_ready), 32'd1);
        check_eq("flush_status", 32'(status), 32'b0010);
        for (int k = 0; k < 5; k++) begin
            step();
            check_eq($sformatf("flush_quiet%0d", k), 32'(out_valid), 32'd0);
        end
        check_eq("flush_res", alu_result, 32'd0);
        check_eq("flush_status_end", 32'(status), 32'b0010);

        // Asynchronous reset in the middle of a multiply
        issue(EXE_SUB, 32'h8000_0000, 32'd1, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check_eq("pre_rst_res", alu_result, 32'h7FFF_FFFF);
        issue(EXE_MUL, 32'd3, 32'd3, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        step();
        #2 rst = 1'b0;
        #1;
        check_eq("arst_valid", 32'(out_valid), 32'd0);
        check_eq("arst_res", alu_result, 32'd0);
        check_eq("arst_br", br_addr, 32'd0);
        check_eq("arst_st", st_data, 32'd0);
        check_eq("arst_status", 32'(status), 32'd0);
        check_eq("arst_ready", 32'(in_ready), 32'd1);
        #2 rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check_eq($sformatf("arst_quiet%0d", k), 32'(out_valid), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/exe_stage_pipe.md
Name: exe_stage_pipe

Overview:
Parametrised, registered execute stage for the ARM-style 5-stage pipeline; successor to the combinational EXE stage.
- Adds valid/ready handshake on both sides, an internal status register (SR) with S-bit update, an iterative multicycle multiply, and flush.
- Sits between the ID/EXE pipeline register and the MEM stage.
- Drives the ALU result, branch target, store data and flags to MEM/IF.

Parameters:
DW, 32, datapath width (>=16); shift and rotate amounts are taken modulo DW.
MUL_LAT, 4, multiply latency in cycles, >=1.
BR_SHIFT, 0, left shift applied to the sign-extended 24-bit branch offset.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
in_valid  in  1  upstream holds a valid instruction.
in_ready  out  1  stage accepts this cycle.
exe_cmd  in  4  operation (package encoding).
mem_r_en, mem_w_en  in  1 each  load/store; address = Rn + val2.
s_bit  in  1  update SR.
pc  in  DW  PC of the instruction.
val_rn, val_rm  in  DW each  operands.
imm  in  1  immediate operand form.
shift_operand  in  12  shifter field.
signed_imm_24  in  24  branch offset.
flush  in  1  kill accepted and in-flight work.
out_valid  out  1  result register valid.
out_ready  in  1  downstream accepts.
alu_result, br_addr, st_data  out  DW each  registered outputs; st_data = val_rm.
out_mem_r_en, out_mem_w_en  out  1 each  registered pass-through.
status  out  4  SR, bit3 N, bit2 C, bit1 Z, bit0 V.

Behaviour:
Reset (rst low, async): out_valid=0; alu_result, br_addr, st_data, status = 0; state = IDLE.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- Accept = in_valid && in_ready.

val2 generation:
- Memory command: zero-extend shift_operand[11:0].
- imm=1: shift_operand[7:0] rotated right by 2*shift_operand[11:8] within DW.
- Otherwise: val_rm shifted by shift_operand[11:7], type shift_operand[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR).

ALU:
- MOV, MVN, AND, ORR, EOR: update N,Z; C,V unchanged.
- ADD, ADC (cin = SR.C), SUB, SBC (ARM semantics, C = NOT borrow): update N,Z,C,V. V is signed overflow at bit DW-1.
- CMP and TST write flags only; result is still registered.
- LDR/STR compute ADD, never touch SR.
- MUL: low DW bits of val_rn*val_rm; updates N,Z only.

br_addr = pc + (sext(signed_imm_24) << BR_SHIFT), truncated to DW.

State machine:
- IDLE: a non-MUL accept loads output registers at the next edge, so latency is 1 cycle. A MUL accept latches operands, goes to MUL_RUN and loads cnt = MUL_LAT-1.
- MUL_RUN: cnt decrements each cycle. At cnt==0, if (!out_valid || out_ready), load the result and return to IDLE. Otherwise stay, with the result held in the operand latch.
- MUL latency from accept to out_valid = MUL_LAT cycles, with no backpressure.

SR update:
- SR updates on the same edge the result register loads, only if s_bit was set on that instruction.
- This lets a back-to-back ADC see the new C.

Output handshake:
- out_valid falls on out_ready with no new load.
- Outputs stay stable while out_valid && !out_ready.

flush (synchronous):
- Next edge: out_valid=0, state=IDLE, any in-flight MUL discarded, no SR update.
- in_valid is ignored in that cycle.

Simultaneous events:
- out_ready and a new load on the same edge: the new data replaces the old, out_valid stays 1.
- flush has priority over everything except reset.

Optional Feature:
EXE_STALL_CNT_EN: adds output stall_cnt (32 bits).
- Increments each cycle in_valid && !in_ready, saturates at 0xFFFFFFFF, resets to 0. It is not cleared by flush.
- Without the macro the port and counter are absent; all other behaviour is identical.

Decomposition:
Package exe_pkg holds:
- EXE_CMD localparams: MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000, MUL 1010. CMP reuses SUB and TST reuses AND, each with no result write-back. LDR/STR use ADD.
- Shift-type codes.
- SR bit indices.
- State enum IDLE/MUL_RUN.

One sub-module, exe_val2_shifter: combinational val2 generation, parametrised by DW.

Test Plan:
- ADD rn=5, rm=7, shift_operand=0, s_bit=1 -> next cycle out_valid=1, alu_result=12, status=0000.
- SUB rn=0x80000000, rm=1, s_bit=1 -> alu_result=0x7FFFFFFF; N0, C1, Z0, V1.
- MOV imm=1, shift_operand=0x2FF -> alu_result=0xF000000F; br_addr = pc + sext(offset).
- MUL rn=3, rm=0xFFFFFFFE, MUL_LAT=4, s_bit=1 -> in_ready low 4 cycles; out_valid at accept+4; alu_result=0xFFFFFFFA; N=1.
- out_ready low 3 cycles with out_valid=1 -> outputs and SR stable, in_ready=0. Then SUB 0-1 (S) followed by ADC 0+0 -> ADC result 0, since C=0 after the borrow.
- Flush in MUL_RUN cycle 2 -> no out_valid, SR unchanged, in_ready=1 next cycle. Separately, rst low mid-MUL -> all outputs 0 immediately.
